yuv_rd_arbiter: RTL and testbench
=================================

// Module: yuv_rd_arbiter
// PURPOSE
//  Shares the single YUV lookup read port (start pulse + address -> data_vld + data) between
//  NUM_CH requesting SFP channels. Round-robin arbitration, one outstanding read at a time,
//  per-read timeout. Returns result and ack to the winning channel. Sits between the per-channel
//  dispatch logic and the DDR-backed YUV read engine.
// PARAMETERS
//  NUM_CH   7     number of requesting channels (1..8)
//  CH_W     3     width of grant_id; must satisfy 2**CH_W >= NUM_CH
//  ADDR_W   32    lookup address width
//  DATA_W   8     lookup result width
//  TIMEOUT  1000  max cycles spent in WAIT before abandoning a read (>=2)
// PORTS
//  clk_sys      in   1              system clock, all logic on rising edge
//  rst_sys_n    in   1              asynchronous reset, active low
//  enable       in   1              arbitration enable (tie to ddr_initdone)
//  req          in   NUM_CH         per-channel level request; held until its ack
//  req_addr     in   NUM_CH*ADDR_W  channel k address at [(k+1)*ADDR_W-1 : k*ADDR_W]
//  ack          out  NUM_CH         one-hot 1-cycle pulse: transaction done for channel k
//  rsp_data     out  DATA_W         result; valid while ack != 0, then held
//  rsp_timeout  out  1              valid with ack: 1 = read timed out, rsp_data = 0
//  rd_start     out  1              1-cycle read start pulse to YUV engine
//  rd_addr      out  ADDR_W         read address, stable from rd_start until next grant
//  rd_data_vld  in   1              read result strobe from YUV engine
//  rd_data      in   DATA_W         read result, sampled when rd_data_vld = 1
//  busy         out  1              1 whenever FSM is not in IDLE
//  grant_id     out  CH_W           index of channel currently or last granted
//  to_count     out  16             number of timeouts since reset, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset: all outputs 0; FSM = IDLE; rr pointer = NUM_CH-1 (channel 0 has top priority).
//  All outputs are registered.
//  FSM states: IDLE, ARB, ISSUE, WAIT, RESP.
//   IDLE : if enable && |(req & ~mask) -> ARB; otherwise stay in IDLE.
//   ARB  : winner = first set bit of (req & ~mask), scanning ptr+1, ptr+2, ... modulo NUM_CH;
//          latch grant_id and rd_addr = req_addr[winner] -> ISSUE.
//   ISSUE: rd_start = 1 for exactly this cycle; clear timer -> WAIT.
//   WAIT : timer increments each cycle. If rd_data_vld = 1: latch rsp_data = rd_data,
//          rsp_timeout = 0 -> RESP. Else if timer == TIMEOUT-1: rsp_data = 0, rsp_timeout = 1,
//          to_count += 1 (saturating) -> RESP. WAIT therefore lasts at most TIMEOUT cycles.
//   RESP : ack[grant_id] = 1 for this cycle only; ptr = grant_id -> IDLE.
//  mask: one-hot of the channel acked in the previous cycle, applied only during the IDLE
//   cycle right after RESP, so a stale req is not re-granted. Otherwise mask = 0.
//  Latency: req first sampled in IDLE at cycle T -> rd_start at T+2. rd_data_vld sampled at
//   cycle W -> ack at W+1.
//  rd_data_vld outside WAIT (including during ISSUE) is ignored. If rd_data_vld and timer
//   expiry coincide, data wins: rsp_timeout = 0, to_count unchanged.
//  A req that drops before it is granted is simply not served. req and req_addr changes after
//   the grant do not affect the read in flight.
//  If enable falls mid-transaction, the current read completes through RESP and no new grant
//   is made. Assertion of rst_sys_n low at any point aborts the read immediately; no ack is
//   issued.
//  busy = 0 only in IDLE. grant_id and rd_addr hold their last values while in IDLE.
// TESTING
//  1 Single req[2] with addr 0x0000_1234; engine returns vld+0x5A 10 cycles after rd_start ->
//    rd_addr = 0x1234, ack = 7'b0000100, rsp_data = 8'h5A, rsp_timeout = 0.
//  2 req = 7'h7F held continuously (each channel re-asserts after its ack) -> grants follow
//    0,1,2,3,4,5,6,0 with no repeats and no skips.
//  3 req[4], engine never answers -> ack[4] exactly TIMEOUT+1 cycles after rd_start,
//    rsp_timeout = 1, rsp_data = 0, to_count increments by 1.
//  4 rd_data_vld lands on the final WAIT cycle (timer = 999) -> data accepted,
//    rsp_timeout = 0, to_count unchanged. A stray vld during IDLE -> no ack.
//  5 enable = 0 with req[0] = 1 -> no rd_start. Drop enable during WAIT -> the pending read
//    still acks, and no further rd_start follows.
//  6 rst_sys_n low during WAIT -> all outputs 0 and no ack. After release with req[6] and req[1]
//    pending -> channel 1 is granted first.

Source files
------------

// File: rtl/yuv_rd_arbiter.sv
// Round-robin arbiter sharing one YUV lookup read port between NUM_CH channels.
// One read in flight at a time; each read is abandoned after TIMEOUT cycles in WAIT.
module yuv_rd_arbiter #(
   parameter int NUM_CH  = 7,
   parameter int CH_W    = 3,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 1000
) (
   input  logic                       clk_sys,
   input  logic                       rst_sys_n,
   input  logic                       enable,
   input  logic [NUM_CH-1:0]          req,
   input  logic [NUM_CH*ADDR_W-1:0]   req_addr,
   output logic [NUM_CH-1:0]          ack,
   output logic [DATA_W-1:0]          rsp_data,
   output logic                       rsp_timeout,
   output logic                       rd_start,
   output logic [ADDR_W-1:0]          rd_addr,
   input  logic                       rd_data_vld,
   input  logic [DATA_W-1:0]          rd_data,
   output logic                       busy,
   output logic [CH_W-1:0]            grant_id,
   output logic [15:0]                to_count
);

   localparam int TMR_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE,
      ARB,
      ISSUE,
      WAIT,
      RESP
   } state_t;

   state_t              state_reg, state_next;
   logic [CH_W-1:0]     ptr_reg, ptr_next;
   logic [NUM_CH-1:0]   mask_reg, mask_next;
   logic [TMR_W-1:0]    timer_reg, timer_next;
   logic [NUM_CH-1:0]   ack_reg, ack_next;
   logic [DATA_W-1:0]   rsp_data_reg, rsp_data_next;
   logic                rsp_timeout_reg, rsp_timeout_next;
   logic                rd_start_reg, rd_start_next;
   logic [ADDR_W-1:0]   rd_addr_reg, rd_addr_next;
   logic                busy_reg, busy_next;
   logic [CH_W-1:0]     grant_id_reg, grant_id_next;
   logic [15:0]         to_count_reg, to_count_next;

   logic [ADDR_W-1:0]   addr_arr [NUM_CH];
   logic [NUM_CH-1:0]   grant_onehot;
   logic [NUM_CH-1:0]   req_eff;

   logic                win_found;
   logic [CH_W-1:0]     win_id;
   logic [ADDR_W-1:0]   win_addr;
   logic [CH_W-1:0]     scan_id;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         assign addr_arr[gi]     = req_addr[gi*ADDR_W +: ADDR_W];
         assign grant_onehot[gi] = (grant_id_reg == CH_W'(gi));
      end
   endgenerate

   // mask is nonzero only in the IDLE cycle right after RESP, hiding the just-acked channel
   assign req_eff = req & ~mask_reg;

   // Scan ptr+1, ptr+2, ... so the last granted channel has the lowest priority
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      win_addr  = '0;
      scan_id   = '0;
      for (int off = 1; off <= NUM_CH; off++) begin
         scan_id = CH_W'((int'(ptr_reg) + off) % NUM_CH);
         if (!win_found && req_eff[scan_id]) begin
            win_found = 1'b1;
            win_id    = scan_id;
            win_addr  = addr_arr[scan_id];
         end
      end
   end

   always_comb begin
      state_next       = state_reg;
      ptr_next         = ptr_reg;
      mask_next        = '0;
      timer_next       = timer_reg;
      ack_next         = '0;
      rsp_data_next    = rsp_data_reg;
      rsp_timeout_next = rsp_timeout_reg;
      rd_start_next    = 1'b0;
      rd_addr_next     = rd_addr_reg;
      grant_id_next    = grant_id_reg;
      to_count_next    = to_count_reg;

      case (state_reg)
         IDLE: begin
            if (enable && (|req_eff)) begin
               state_next = ARB;
            end
         end
         ARB: begin
            // A request that vanished since IDLE is simply not served
            if (enable && win_found) begin
               grant_id_next = win_id;
               rd_addr_next  = win_addr;
               rd_start_next = 1'b1;
               state_next    = ISSUE;
            end else begin
               state_next = IDLE;
            end
         end
         ISSUE: begin
            timer_next = '0;
            state_next = WAIT;
         end
         WAIT: begin
            timer_next = timer_reg + 1'b1;
            if (rd_data_vld) begin
               rsp_data_next    = rd_data;
               rsp_timeout_next = 1'b0;
               ack_next         = grant_onehot;
               state_next       = RESP;
            end else if (timer_reg == TMR_W'(TIMEOUT - 1)) begin
               rsp_data_next    = '0;
               rsp_timeout_next = 1'b1;
               ack_next         = grant_onehot;
               if (to_count_reg != 16'hFFFF) begin
                  to_count_next = to_count_reg + 16'd1;
               end
               state_next = RESP;
            end
         end
         RESP: begin
            ptr_next   = grant_id_reg;
            mask_next  = grant_onehot;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      busy_next = (state_next != IDLE);
   end

   always_ff @(posedge clk_sys or negedge rst_sys_n) begin
      if (!rst_sys_n) begin
         state_reg       <= IDLE;
         ptr_reg         <= CH_W'(NUM_CH - 1);
         mask_reg        <= '0;
         timer_reg       <= '0;
         ack_reg         <= '0;
         rsp_data_reg    <= '0;
         rsp_timeout_reg <= 1'b0;
         rd_start_reg    <= 1'b0;
         rd_addr_reg     <= '0;
         busy_reg        <= 1'b0;
         grant_id_reg    <= '0;
         to_count_reg    <= '0;
      end else begin
         state_reg       <= state_next;
         ptr_reg         <= ptr_next;
         mask_reg        <= mask_next;
         timer_reg       <= timer_next;
         ack_reg         <= ack_next;
         rsp_data_reg    <= rsp_data_next;
         rsp_timeout_reg <= rsp_timeout_next;
         rd_start_reg    <= rd_start_next;
         rd_addr_reg     <= rd_addr_next;
         busy_reg        <= busy_next;
         grant_id_reg    <= grant_id_next;
         to_count_reg    <= to_count_next;
      end
   end

   assign ack         = ack_reg;
   assign rsp_data    = rsp_data_reg;
   assign rsp_timeout = rsp_timeout_reg;
   assign rd_start    = rd_start_reg;
   assign rd_addr     = rd_addr_reg;
   assign busy        = busy_reg;
   assign grant_id    = grant_id_reg;
   assign to_count    = to_count_reg;

endmodule

// File: tb/tb_yuv_rd_arbiter.sv
// Directed bench for yuv_rd_arbiter: expected acks are queued when a request is
// driven and checked by the per-cycle sampler when the DUT acks.
module tb_yuv_rd_arbiter;

   localparam int NUM_CH  = 7;
   localparam int CH_W    = 3;
   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 8;
   localparam int TIMEOUT = 1000;

   logic                     clk_sys = 1'b0;
   logic                     rst_sys_n;
   logic                     enable;
   logic [NUM_CH-1:0]        req;
   logic [NUM_CH*ADDR_W-1:0] req_addr;
   logic [NUM_CH-1:0]        ack;
   logic [DATA_W-1:0]        rsp_data;
   logic                     rsp_timeout;
   logic                     rd_start;
   logic [ADDR_W-1:0]        rd_addr;
   logic                     rd_data_vld;
   logic [DATA_W-1:0]        rd_data;
   logic                     busy;
   logic [CH_W-1:0]          grant_id;
   logic [15:0]              to_count;

   always #5 clk_sys = ~clk_sys;

   yuv_rd_arbiter #(
      .NUM_CH (NUM_CH),
      .CH_W   (CH_W),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk_sys    (clk_sys),
      .rst_sys_n  (rst_sys_n),
      .enable     (enable),
      .req        (req),
      .req_addr   (req_addr),
      .ack        (ack),
      .rsp_data   (rsp_data),
      .rsp_timeout(rsp_timeout),
      .rd_start   (rd_start),
      .rd_addr    (rd_addr),
      .rd_data_vld(rd_data_vld),
      .rd_data    (rd_data),
      .busy       (busy),
      .grant_id   (grant_id),
      .to_count   (to_count)
   );

   typedef struct {
      logic [NUM_CH-1:0] ack;
      logic [7:0]        data;
      logic              to;
   } exp_t;

   exp_t        exp_q[$];
   int          n_tests = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          n_start = 0;
   int          n_ack = 0;
   int          last_start_cyc = 0;
   int          last_ack_cyc = 0;
   bit          seen_start = 1'b0;
   logic [15:0] exp_to_count = 16'd0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   task automatic push_exp(input int ch, input logic [7:0] d, input logic to);
      exp_t e;
      logic [NUM_CH-1:0] one;
      one   = 1;
      e.ack = one << ch;
      e.data = d;
      e.to   = to;
      exp_q.push_back(e);
      $display("[TB] cycle %0d: expect ack ch%0d data 0x%02h timeout %0b", cyc, ch, d, to);
   endtask

   // One clock; outputs sampled 1 time unit after the rising edge
   task automatic tick();
      exp_t e;
      @(posedge clk_sys);
      #1;
      cyc++;
      if (rd_start === 1'b1) begin
         seen_start     = 1'b1;
         n_start++;
         last_start_cyc = cyc;
         $display("[TB] cycle %0d: rd_start grant %0d addr 0x%08h", cyc, grant_id, rd_addr);
      end
      if (ack !== '0) begin
         n_ack++;
         last_ack_cyc = cyc;
         $display("[TB] cycle %0d: ack 0x%02h data 0x%02h timeout %0b", cyc, ack, rsp_data, rsp_timeout);
         if (exp_q.size() == 0) begin
            check("unexpected_ack", 32'(ack), 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("ack", 32'(ack), 32'(e.ack));
            check("rsp_data", 32'(rsp_data), 32'(e.data));
            check("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
         end
      end
   endtask

   task automatic wait_start();
      seen_start = 1'b0;
      for (int i = 0; i < 20 && !seen_start; i++) tick();
      check("start_seen", 32'(seen_start), 32'd1);
   endtask

   task automatic set_addr(input int ch, input logic [31:0] a);
      req_addr[ch*ADDR_W +: ADDR_W] = a;
   endtask

   // dly >= 1: vld in WAIT cycle dly after rd_start; 0: vld during ISSUE only; <0: silent
   task automatic run_read(input int ch, input logic [31:0] addr, input int dly, input logic [7:0] d);
      int   c0;
      int   s;
      int   acks0;
      int   exp_ack_cyc;
      logic timed_out;
      tick();
      timed_out = (dly < 1);
      set_addr(ch, addr);
      req[ch] = 1'b1;
      push_exp(ch, timed_out ? 8'h00 : d, timed_out);
      c0    = cyc;
      acks0 = n_ack;
      wait_start();
      check("start_latency", 32'(last_start_cyc), 32'(c0 + 2));
      check("grant_id", 32'(grant_id), 32'(ch));
      check("rd_addr", rd_addr, addr);
      s = last_start_cyc;
      set_addr(ch, ~addr);
      if (!timed_out) begin
         repeat (dly) tick();
         rd_data_vld = 1'b1;
         rd_data     = d;
         tick();
         rd_data_vld = 1'b0;
         exp_ack_cyc = s + dly + 1;
      end else begin
         if (dly == 0) begin
            rd_data_vld = 1'b1;
            rd_data     = d;
            tick();
            rd_data_vld = 1'b0;
            repeat (TIMEOUT) tick();
         end else begin
            repeat (TIMEOUT + 1) tick();
         end
         exp_ack_cyc  = s + TIMEOUT + 1;
         exp_to_count = exp_to_count + 16'd1;
      end
      check("ack_latency", 32'(last_ack_cyc), 32'(exp_ack_cyc));
      check("ack_count", 32'(n_ack - acks0), 32'd1);
      check("rd_addr_hold", rd_addr, addr);
      check("to_count", 32'(to_count), 32'(exp_to_count));
      req[ch] = 1'b0;
   endtask

   initial begin
      int acks0;
      int st0;
      int ch;
      rst_sys_n   = 1'b0;
      enable      = 1'b0;
      req         = '0;
      req_addr    = '0;
      rd_data_vld = 1'b0;
      rd_data     = '0;
      tick();
      tick();
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_rsp_data", 32'(rsp_data), 32'd0);
      check("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
      check("rst_rd_start", 32'(rd_start), 32'd0);
      check("rst_rd_addr", rd_addr, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_grant_id", 32'(grant_id), 32'd0);
      check("rst_to_count", 32'(to_count), 32'd0);
      rst_sys_n = 1'b1;
      tick();
      enable = 1'b1;

      // single read, answer 10 cycles after rd_start
      run_read(2, 32'h0000_1234, 10, 8'h5A);
      tick();
      tick();
      check("idle_busy", 32'(busy), 32'd0);
      run_read(6, 32'h6666_0006, 4, 8'h66);

      // all channels requesting continuously: strict rotation from channel 0
      for (int k = 0; k < NUM_CH; k++) set_addr(k, 32'h100 + k);
      req = '1;
      for (int i = 0; i < 8; i++) begin
         ch = i % NUM_CH;
         push_exp(ch, 8'(8'hA0 + i), 1'b0);
         wait_start();
         check("rr_grant", 32'(grant_id), 32'(ch));
         check("rr_addr", rd_addr, 32'(32'h100 + ch));
         repeat (3) tick();
         rd_data_vld = 1'b1;
         rd_data     = 8'(8'hA0 + i);
         tick();
         rd_data_vld = 1'b0;
      end
      req = '0;
      repeat (4) tick();

      // timeout, then data on the final WAIT cycle, then vld outside WAIT
      run_read(4, 32'hDEAD_0004, -1, 8'h00);
      run_read(3, 32'h0003_3333, TIMEOUT, 8'hC3);
      acks0 = n_ack;
      repeat (2) tick();
      rd_data_vld = 1'b1;
      rd_data     = 8'hFF;
      tick();
      rd_data_vld = 1'b0;
      repeat (3) tick();
      check("stray_vld_acks", 32'(n_ack - acks0), 32'd0);
      check("stray_vld_data_held", 32'(rsp_data), 32'h0000_00C3);
      check("stray_vld_busy", 32'(busy), 32'd0);
      run_read(5, 32'h0005_5555, 0, 8'hEE);

      // enable gating
      enable = 1'b0;
      st0    = n_start;
      set_addr(0, 32'h0000_00A0);
      req[0] = 1'b1;
      repeat (20) tick();
      check("disabled_no_start", 32'(n_start - st0), 32'd0);
      check("disabled_busy", 32'(busy), 32'd0);
      push_exp(0, 8'h77, 1'b0);
      enable = 1'b1;
      wait_start();
      check("en_grant", 32'(grant_id), 32'd0);
      st0   = n_start;
      acks0 = n_ack;
      repeat (2) tick();
      enable = 1'b0;
      req[5] = 1'b1;
      repeat (2) tick();
      rd_data_vld = 1'b1;
      rd_data     = 8'h77;
      tick();
      rd_data_vld = 1'b0;
      req[0]      = 1'b0;
      repeat (20) tick();
      check("en_drop_ack", 32'(n_ack - acks0), 32'd1);
      check("en_drop_no_start", 32'(n_start - st0), 32'd0);
      check("en_drop_busy", 32'(busy), 32'd0);

      // reset during WAIT aborts the read; priority restarts at channel 0
      req    = '0;
      enable = 1'b1;
      set_addr(3, 32'h0303_0303);
      req[3] = 1'b1;
      wait_start();
      repeat (3) tick();
      rst_sys_n = 1'b0;
      req       = '0;
      tick();
      check("arst_ack", 32'(ack), 32'd0);
      check("arst_rsp_data", 32'(rsp_data), 32'd0);
      check("arst_rsp_timeout", 32'(rsp_timeout), 32'd0);
      check("arst_rd_start", 32'(rd_start), 32'd0);
      check("arst_rd_addr", rd_addr, 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_grant_id", 32'(grant_id), 32'd0);
      check("arst_to_count", 32'(to_count), 32'd0);
      exp_to_count = 16'd0;
      tick();
      set_addr(1, 32'h0000_0011);
      set_addr(6, 32'h0000_0016);
      req = 7'b100_0010;
      push_exp(1, 8'h11, 1'b0);
      rst_sys_n = 1'b1;
      wait_start();
      check("post_rst_grant", 32'(grant_id), 32'd1);
      repeat (2) tick();
      rd_data_vld = 1'b1;
      rd_data     = 8'h11;
      tick();
      rd_data_vld = 1'b0;
      req[1]      = 1'b0;
      push_exp(6, 8'h16, 1'b0);
      wait_start();
      check("post_rst_grant2", 32'(grant_id), 32'd6);
      check("post_rst_addr2", rd_addr, 32'h0000_0016);
      repeat (2) tick();
      rd_data_vld = 1'b1;
      rd_data     = 8'h16;
      tick();
      rd_data_vld = 1'b0;
      req[6]      = 1'b0;
      repeat (5) tick();
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
